// File: rtl/encoder_pkg.sv
// encoder_pkg: shared FSM state type and default sizes for request_encoder.
package encoder_pkg;
   typedef enum logic {IDLE, EMIT} state_t;
   localparam int NUM_LINES_DEF = 4;
   localparam int ADDR_W_DEF    = 2;
endpackage

// File: rtl/request_encoder_if.sv
// request_encoder_if: input-vector and output-address handshakes of request_encoder.
// Signals: in_valid/in_ready/lines (vector in), out_valid/out_ready/address/out_last (beats out),
// err (zero-vector pulse, present only when ENCODER_ERR_EN is defined).
// master = producer/consumer side, slave = request_encoder.
interface request_encoder_if #(
   parameter int NUM_LINES = encoder_pkg::NUM_LINES_DEF,
   parameter int ADDR_W    = encoder_pkg::ADDR_W_DEF
);
   logic                 in_valid;
   logic                 in_ready;
   logic [NUM_LINES-1:0] lines;
   logic                 out_valid;
   logic                 out_ready;
   logic [ADDR_W-1:0]    address;
   logic                 out_last;
`ifdef ENCODER_ERR_EN
   logic                 err;
   modport master (output in_valid, lines, out_ready, input in_ready, out_valid, address, out_last, err);
   modport slave  (input in_valid, lines, out_ready, output in_ready, out_valid, address, out_last, err);
`else
   modport master (output in_valid, lines, out_ready, input in_ready, out_valid, address, out_last);
   modport slave  (input in_valid, lines, out_ready, output in_ready, out_valid, address, out_last);
`endif
endinterface

// File: rtl/priority_index.sv
// priority_index: combinational lowest-set-bit encoder.
// Ports: pending (in), index of lowest set bit, is_last (exactly one bit set), rest (pending minus that bit).
module priority_index #(
   parameter int NUM_LINES = 4,
   parameter int ADDR_W    = 2
) (
   input  logic [NUM_LINES-1:0] pending,
   output logic [ADDR_W-1:0]    index,
   output logic                 is_last,
   output logic [NUM_LINES-1:0] rest
);
   always_comb begin
      index = '0;
      for (int i = NUM_LINES - 1; i >= 0; i--)
         if (pending[i]) index = ADDR_W'(i);
   end
   // x & (x-1) clears the lowest set bit
   assign rest    = pending & (pending - NUM_LINES'(1));
   assign is_last = |pending && rest == '0;
endmodule

// File: rtl/request_encoder.sv
// request_encoder: accepts a request-line vector and emits one address beat per set bit, lowest first.
// Ports: clk, reset_n (async active-low), bus (request_encoder_if.slave).
// Optional macro ENCODER_ERR_EN adds the err pulse for rejected all-zero vectors.
module request_encoder
   import encoder_pkg::*;
#(
   parameter int NUM_LINES = NUM_LINES_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input logic              clk,
   input logic              reset_n,
   request_encoder_if.slave bus
);
   if (NUM_LINES < 2 || NUM_LINES > 16 || ADDR_W != $clog2(NUM_LINES)) begin : g_bad_cfg
      $error("request_encoder: NUM_LINES must be 2..16 and ADDR_W must equal clog2(NUM_LINES)");
   end
   state_t               state, state_d;
   logic [NUM_LINES-1:0] pending, pending_d, rest;
   logic [ADDR_W-1:0]    index;
   logic                 is_last, ready_en, take;
   priority_index #(.NUM_LINES(NUM_LINES), .ADDR_W(ADDR_W)) u_pri (
      .pending(pending),
      .index(index),
      .is_last(is_last),
      .rest(rest)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state    <= IDLE;
         pending  <= '0;
         ready_en <= 1'b0;
      end else begin
         state    <= state_d;
         pending  <= pending_d;
         ready_en <= 1'b1;
      end
   assign take = bus.in_valid && bus.in_ready;
   always_comb begin
      state_d   = state;
      pending_d = pending;
      if (state == IDLE) begin
         if (take && |bus.lines) begin
            pending_d = bus.lines;
            state_d   = EMIT;
         end
      end else if (bus.out_ready) begin
         pending_d = rest;
         state_d   = is_last ? IDLE : EMIT;
      end
   end
   // ready_en keeps in_ready low until the first clock edge after reset release
   assign bus.in_ready  = ready_en && state == IDLE;
   assign bus.out_valid = state == EMIT;
   assign bus.address   = state == EMIT ? index : '0;
   assign bus.out_last  = state == EMIT && is_last;
`ifdef ENCODER_ERR_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) bus.err <= 1'b0;
      else bus.err <= take && bus.lines == '0;
`endif
endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder: randomized and directed bench for request_encoder against a queue-based model.
module tb_request_encoder;
   localparam int N = 4;
   logic clk = 1'b0;
   logic reset_n;
   int   n_chk = 0;
   int   n_pass = 0;
   int   q[$];
   bit   live;
   bit   exp_err;
   request_encoder_if #(.NUM_LINES(N), .ADDR_W(2)) bus ();
   request_encoder #(.NUM_LINES(N), .ADDR_W(2)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask
   task automatic check_outputs(input string tag);
      chk({tag, ".in_ready"}, int'(bus.in_ready), int'(live && q.size() == 0));
      chk({tag, ".out_valid"}, int'(bus.out_valid), int'(q.size() > 0));
      chk({tag, ".address"}, int'(bus.address), q.size() > 0 ? q[0] : 0);
      chk({tag, ".out_last"}, int'(bus.out_last), int'(q.size() == 1));
`ifdef ENCODER_ERR_EN
      chk({tag, ".err"}, int'(bus.err), int'(exp_err));
`endif
   endtask
   // one clock: drive inputs, advance the model by the same handshake rules, compare after the edge
   task automatic step(input string tag, input logic iv, input logic [N-1:0] ln, input logic ordy);
      bus.in_valid  = iv;
      bus.lines     = ln;
      bus.out_ready = ordy;
      exp_err = 0;
      if (live && q.size() == 0) begin
         if (iv && ln != 0) begin
            for (int i = 0; i < N; i++) if (ln[i]) q.push_back(i);
         end else if (iv) exp_err = 1;
      end else if (q.size() > 0 && ordy) void'(q.pop_front());
      live = 1;
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #2;
      q.delete();
      live = 0;
      exp_err = 0;
      check_outputs({tag, ".async"});
      bus.in_valid  = 1'b1;
      bus.lines     = 4'b0011;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_outputs({tag, ".held"});
      reset_n = 1'b1;
      #1;
      check_outputs({tag, ".released"});
   endtask
   initial begin
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.lines     = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset("rst0");
      step("first", 0, 4'b0000, 1);
      step("a1010", 1, 4'b1010, 1);
      step("a1010", 0, 4'b0000, 1);
      step("a1010", 0, 4'b0000, 1);
      step("a1111", 1, 4'b1111, 1);
      for (int i = 0; i < 8; i++) step("a1111", 0, 4'b0000, i % 2 == 0);
      step("zero", 1, 4'b0000, 1);
      step("zero", 0, 4'b0000, 1);
      step("zero", 0, 4'b0000, 1);
      step("r0110", 1, 4'b0110, 1);
      step("r0110", 0, 4'b0000, 1);
      do_reset("rst1");
      step("r0110", 0, 4'b0000, 1);
      step("r0110", 0, 4'b0000, 1);
      step("b2b", 1, 4'b1000, 1);
      step("b2b", 1, 4'b0001, 1);
      step("b2b", 1, 4'b0001, 1);
      step("b2b", 0, 4'b0000, 1);
      step("b2b", 0, 4'b0000, 1);
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] ln;
         ln = ($urandom % 5 == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         if (i == 200) do_reset("rst_rand");
         step("rand", 1'($urandom % 2), ln, 1'($urandom % 3 != 0));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
